maze_env: RTL and testbench

- Behavioural/synthesizable model of the robot's world: an 8x8 walled grid plus the robot's pose.
- Consumes the wall-follower's motion commands (front, turn) and produces its sensor inputs (front_sensor, left_sensor). This closes the loop for simulation and FPGA demo.
- Also reports pose, collisions, step count and maze completion.

---
 rtl/maze_env_pkg.sv | 29 ++
 rtl/maze_map.sv | 71 +++++++
 rtl/maze_env.sv | 124 ++++++++++++
 tb/tb_maze_env.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_env_pkg.sv
// rtl/maze_env_pkg.sv - shared encodings for the maze environment
// Purpose: heading and command encodings, wall-bit positions in map_data.
// Ports: none (package).
package maze_env_pkg;

  typedef enum logic [1:0] {
    HEAD_N = 2'd0,
    HEAD_E = 2'd1,
    HEAD_S = 2'd2,
    HEAD_W = 2'd3
  } head_t;

  // Command as {front, turn}
  typedef enum logic [1:0] {
    CMD_HOLD  = 2'b00,
    CMD_TURN  = 2'b01,
    CMD_FRONT = 2'b10,
    CMD_BOTH  = 2'b11
  } cmd_t;

  localparam int WALL_N_BIT = 1;
  localparam int WALL_W_BIT = 0;

  // Direction on the robot's left: one quarter turn counter-clockwise
  function automatic logic [1:0] left_of(input logic [1:0] h);
    return h + 2'd3;
  endfunction

endpackage

// File: rtl/maze_map.sv
// rtl/maze_map.sv - wall map storage with border forcing and two wall queries
// Purpose: holds nwall/wwall per cell, cleared on reset; answers wall(x,y,d).
// Ports: clk, rst_n; map_we/map_x/map_y/map_data write port;
//        q0_x/q0_y/q0_dir -> q0_wall and q1_x/q1_y/q1_dir -> q1_wall queries.
module maze_map
  import maze_env_pkg::*;
#(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter int XW     = $clog2(GRID_W),
  parameter int YW     = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          map_we,
  input  logic [XW-1:0] map_x,
  input  logic [YW-1:0] map_y,
  input  logic [1:0]    map_data,
  input  logic [XW-1:0] q0_x,
  input  logic [YW-1:0] q0_y,
  input  logic [1:0]    q0_dir,
  output logic          q0_wall,
  input  logic [XW-1:0] q1_x,
  input  logic [YW-1:0] q1_y,
  input  logic [1:0]    q1_dir,
  output logic          q1_wall
);

  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  logic [GRID_H-1:0][GRID_W-1:0] nwall;
  logic [GRID_H-1:0][GRID_W-1:0] wwall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nwall <= '0;
      wwall <= '0;
    end else if (map_we) begin
      nwall[map_y][map_x] <= map_data[WALL_N_BIT];
      wwall[map_y][map_x] <= map_data[WALL_W_BIT];
    end
  end

  // Border walls are applied here rather than stored, so no write can open them.
  // S and E look at the neighbour cell, whose own N/W bit is never a border bit.
  function automatic logic wall_q(
    input logic [GRID_H-1:0][GRID_W-1:0] nw,
    input logic [GRID_H-1:0][GRID_W-1:0] ww,
    input logic [XW-1:0]                 x,
    input logic [YW-1:0]                 y,
    input logic [1:0]                    d
  );
    logic r;
    r = 1'b1;
    case (head_t'(d))
      HEAD_N: r = (y == '0) | nw[y][x];
      HEAD_W: r = (x == '0) | ww[y][x];
      HEAD_S: r = (y == Y_MAX) ? 1'b1 : nw[y + YW'(1)][x];
      HEAD_E: r = (x == X_MAX) ? 1'b1 : ww[y][x + XW'(1)];
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  always_comb begin
    q0_wall = wall_q(nwall, wwall, q0_x, q0_y, q0_dir);
    q1_wall = wall_q(nwall, wwall, q1_x, q1_y, q1_dir);
  end

endmodule

// File: rtl/maze_env.sv
// rtl/maze_env.sv - robot world: pose, sensors, command decode, completion
// Purpose: applies front/turn commands to the robot pose on an 8x8 walled grid
//          and produces the wall sensors, bump/cmd_err pulses, done, step count.
// Ports: clk, rst_n; front, turn commands; map_we/map_x/map_y/map_data wall
//        writes; front_sensor, left_sensor; pos_x, pos_y, heading; bump,
//        cmd_err, done, step_count.
module maze_env
  import maze_env_pkg::*;
#(
  parameter int         GRID_W    = 8,
  parameter int         GRID_H    = 8,
  parameter int         START_X   = 0,
  parameter int         START_Y   = 0,
  parameter logic [1:0] START_DIR = 2'd1,
  parameter int         EXIT_X    = 7,
  parameter int         EXIT_Y    = 7,
  parameter int         XW        = $clog2(GRID_W),
  parameter int         YW        = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          front,
  input  logic          turn,
  input  logic          map_we,
  input  logic [XW-1:0] map_x,
  input  logic [YW-1:0] map_y,
  input  logic [1:0]    map_data,
  output logic          front_sensor,
  output logic          left_sensor,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic [1:0]    heading,
  output logic          bump,
  output logic          cmd_err,
  output logic          done,
  output logic [15:0]   step_count
);

  localparam logic [XW-1:0] EXIT_XV       = XW'(EXIT_X);
  localparam logic [YW-1:0] EXIT_YV       = YW'(EXIT_Y);
  localparam logic          START_AT_EXIT = (START_X == EXIT_X) && (START_Y == EXIT_Y);

  logic [1:0]    left_dir;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic          next_at_exit;
  logic [15:0]   step_inc;

  assign left_dir = left_of(heading);

  maze_map #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H),
    .XW    (XW),
    .YW    (YW)
  ) u_map (
    .clk     (clk),
    .rst_n   (rst_n),
    .map_we  (map_we),
    .map_x   (map_x),
    .map_y   (map_y),
    .map_data(map_data),
    .q0_x    (pos_x),
    .q0_y    (pos_y),
    .q0_dir  (heading),
    .q0_wall (front_sensor),
    .q1_x    (pos_x),
    .q1_y    (pos_y),
    .q1_dir  (left_dir),
    .q1_wall (left_sensor)
  );

  // Candidate cell one step ahead; only used when front_sensor says it is open.
  always_comb begin
    next_x = pos_x;
    next_y = pos_y;
    case (head_t'(heading))
      HEAD_N: next_y = pos_y - YW'(1);
      HEAD_E: next_x = pos_x + XW'(1);
      HEAD_S: next_y = pos_y + YW'(1);
      HEAD_W: next_x = pos_x - XW'(1);
      default: ;
    endcase
    next_at_exit = (next_x == EXIT_XV) && (next_y == EXIT_YV);
    step_inc     = (step_count == 16'hFFFF) ? step_count : step_count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_x      <= XW'(START_X);
      pos_y      <= YW'(START_Y);
      heading    <= START_DIR;
      bump       <= 1'b0;
      cmd_err    <= 1'b0;
      done       <= START_AT_EXIT;
      step_count <= '0;
    end else begin
      bump    <= 1'b0;
      cmd_err <= 1'b0;
      if (!done) begin
        case (cmd_t'({front, turn}))
          // Both strobes together resolve to a turn and flag the conflict.
          CMD_TURN, CMD_BOTH: begin
            heading    <= heading + 2'd1;
            step_count <= step_inc;
            cmd_err    <= front;
          end
          CMD_FRONT: begin
            if (front_sensor) begin
              bump <= 1'b1;
            end else begin
              pos_x      <= next_x;
              pos_y      <= next_y;
              step_count <= step_inc;
              done       <= next_at_exit;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_maze_env.sv
// tb/tb_maze_env.sv - scoreboard bench for maze_env against a grid reference model
module tb_maze_env;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       front = 1'b0;
  logic       turn = 1'b0;
  logic       map_we = 1'b0;
  logic [2:0] map_x = '0;
  logic [2:0] map_y = '0;
  logic [1:0] map_data = '0;
  logic       front_sensor, left_sensor;
  logic [2:0] pos_x, pos_y;
  logic [1:0] heading;
  logic       bump, cmd_err, done;
  logic [15:0] step_count;

  always #5 clk = ~clk;

  maze_env dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .front       (front),
    .turn        (turn),
    .map_we      (map_we),
    .map_x       (map_x),
    .map_y       (map_y),
    .map_data    (map_data),
    .front_sensor(front_sensor),
    .left_sensor (left_sensor),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .heading     (heading),
    .bump        (bump),
    .cmd_err     (cmd_err),
    .done        (done),
    .step_count  (step_count)
  );

  typedef struct {
    int px, py, hd, bmp, err, dn, steps, fs, ls;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Reference world: plain arrays of stored wall bits, pose as integers
  bit nw[8][8];
  bit ww[8][8];
  int m_x, m_y, m_h, m_steps;
  bit m_bump, m_err, m_done;

  function automatic bit n_eff(int x, int y);
    return (y == 0) || nw[x][y];
  endfunction

  function automatic bit w_eff(int x, int y);
    return (x == 0) || ww[x][y];
  endfunction

  function automatic bit wall(int x, int y, int d);
    case (d)
      0: return n_eff(x, y);
      1: return (x == 7) ? 1'b1 : w_eff(x + 1, y);
      2: return (y == 7) ? 1'b1 : n_eff(x, y + 1);
      default: return w_eff(x, y);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, and queue the expected result.
  task automatic cyc(input bit r, input bit f, input bit t, input bit we,
                     input int wx, input int wy, input int wd);
    exp_t e;
    @(negedge clk);
    rst_n    = r;
    front    = f;
    turn     = t;
    map_we   = we;
    map_x    = 3'(wx);
    map_y    = 3'(wy);
    map_data = 2'(wd);
    if (!r) begin
      m_x = 0; m_y = 0; m_h = 1; m_steps = 0;
      m_bump = 0; m_err = 0; m_done = 0;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) begin
          nw[i][j] = 0;
          ww[i][j] = 0;
        end
    end else begin
      m_bump = 0;
      m_err  = 0;
      if (!m_done) begin
        if (t) begin
          m_h = (m_h + 1) % 4;
          if (m_steps < 65535) m_steps++;
          m_err = f;
        end else if (f) begin
          if (wall(m_x, m_y, m_h)) begin
            m_bump = 1;
          end else begin
            case (m_h)
              0: m_y--;
              1: m_x++;
              2: m_y++;
              default: m_x--;
            endcase
            if (m_steps < 65535) m_steps++;
            if (m_x == 7 && m_y == 7) m_done = 1;
          end
        end
      end
      if (we) begin
        nw[wx][wy] = wd[1];
        ww[wx][wy] = wd[0];
      end
    end
    e.px = m_x; e.py = m_y; e.hd = m_h;
    e.bmp = m_bump; e.err = m_err; e.dn = m_done; e.steps = m_steps;
    e.fs = wall(m_x, m_y, m_h);
    e.ls = wall(m_x, m_y, (m_h + 3) % 4);
    sbq.push_back(e);
  endtask

  task automatic cmd(input bit f, input bit t);
    cyc(1, f, t, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a new state one step after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("pos_x", 32'(pos_x), 32'(e.px));
        check("pos_y", 32'(pos_y), 32'(e.py));
        check("heading", 32'(heading), 32'(e.hd));
        check("bump", 32'(bump), 32'(e.bmp));
        check("cmd_err", 32'(cmd_err), 32'(e.err));
        check("done", 32'(done), 32'(e.dn));
        check("step_count", 32'(step_count), 32'(e.steps));
        check("front_sensor", 32'(front_sensor), 32'(e.fs));
        check("left_sensor", 32'(left_sensor), 32'(e.ls));
      end
    end
  end

  initial begin
    // Reset, then run east along the empty north row into the east border
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cmd(0, 0);
    for (int i = 0; i < 8; i++) cmd(1, 0);
    cmd(0, 0);

    // Four turns at (3,3)
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cmd(1, 0);
    cmd(0, 1);
    for (int i = 0; i < 3; i++) cmd(1, 0);
    cmd(0, 1);
    cmd(0, 1);
    for (int i = 0; i < 4; i++) cmd(0, 1);

    // Wall written while moving; next front bumps into it
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 2, 0, 1);
    cmd(1, 0);
    cmd(0, 0);

    // Conflicting command
    cmd(1, 1);
    cmd(0, 0);

    // Drive to the exit, then confirm everything is frozen, then reset
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cmd(1, 0);
    cmd(0, 1);
    for (int i = 0; i < 7; i++) cmd(1, 0);
    cmd(1, 0);
    cmd(0, 1);
    cmd(1, 1);
    cyc(1, 0, 0, 1, 7, 7, 3);
    cmd(0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cmd(0, 0);

    // Random commands, wall writes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit r, f, t, we;
      r  = ($urandom_range(0, 199) != 0);
      f  = ($urandom_range(0, 9) < 6);
      t  = ($urandom_range(0, 9) < 3);
      we = ($urandom_range(0, 3) == 0);
      cyc(r, f, t, we, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
    end

    cmd(0, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
